instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the RISC-V core, directly upstream of the instruction decoder/control logic. Holds the program counter, issues requests to instruction memory over a request/response handshake, and presents one registered 32-bit instruction (`ins`) with its PC to the decode stage. When the core consumes the current instruction, the block selects the next PC: sequential `pc+4`, or the ALU-computed target when `pcsel` is high. It then fetches that PC.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- `NOP_INSN`, 32'h0000_0013, value of `ins` while no valid instruction has been fetched (addi x0,x0,0).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset is asynchronous and active-low.
- `advance`  in  1  core consumes the current instruction; honoured only when `ins_valid`=1.
- `pcsel`  in  1  next-PC select; 1 = `alu_target`, 0 = `pc+4`. Sampled only with an honoured `advance`.
- `alu_target`  in  32  branch/jump target from the ALU.
- `imem_req`  out  1  request valid to instruction memory.
- `imem_addr`  out  32  word-aligned fetch address; equals `pc`.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  response instruction word.
- `ins`  out  32  registered instruction to the decoder.
- `ins_valid`  out  1  `ins` is the instruction at `pc`.
- `pc`  out  32  address of `ins` / current fetch.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32.
- `fetch_fault`  out  1  sticky misaligned-target fault.

## Operation
- FSM states: REQ, WAIT, HOLD, FAULT. Reset state is REQ.
- REQ: `imem_req`=1 with `imem_addr`=`pc`. On `imem_ready`=1 go to WAIT. Address and request stay stable until accepted.
- WAIT: `imem_req`=0. On `imem_rvalid`=1, load `ins` <= `imem_rdata` and go to HOLD.
- HOLD: `ins_valid`=1. On `advance`=1:
  - Compute next PC: if `pcsel`=1, next = {`alu_target`[31:1],1'b0}; otherwise next = `pc`+4, wrapping 32'hFFFF_FFFC -> 0.
  - Load `pc` <= next.
  - If next[1]=0, go to REQ. If next[1]=1, go to FAULT.
- FAULT: `fetch_fault`=1, `imem_req`=0, `ins_valid`=0. `pc` holds the offending target. Only reset exits this state.
- `imem_rvalid` is ignored outside WAIT. This includes a stale response arriving after a mid-transaction reset.
- `advance` is ignored outside HOLD. `pcsel` and `alu_target` are don't-care when `advance` is not honoured.
- `ins` keeps its last value outside HOLD; only `ins_valid` qualifies it.
- At most one outstanding memory request at any time.

## Timing
- Reset values: `pc`=`RESET_PC`, `ins`=`NOP_INSN`, `ins_valid`=0, `fetch_fault`=0, `imem_req`=1 (state REQ), `imem_addr`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4.
- Async assertion of `rst_n` forces all of the above immediately. Operation resumes on the first rising edge after deassertion.
- Cycle t: request accepted (`imem_req` & `imem_ready`).
- Cycle >= t+1: `imem_rvalid` is sampled.
- If `imem_rvalid` is seen at cycle r, `ins_valid`=1 from cycle r+1.
- An honoured `advance` at cycle h gives, in cycle h+1: new `pc`, `ins_valid`=0, and `imem_req`=1 (or `fetch_fault`=1).
- Minimum issue interval is 3 cycles per instruction (REQ, WAIT, HOLD), with zero-wait memory.
- `pc_plus4` and `imem_addr` are combinational from `pc`.

## Test plan
- Reset then zero-wait memory returning 0x00500093, with `advance`=1 each cycle: `imem_addr` sequence is 0x0, 0x4, 0x8; `ins_valid` pulses every 3rd cycle; `ins`=0x00500093.
- Memory stalls: `imem_ready` low for 4 cycles, then `rvalid` 2 cycles after grant. Required: `imem_addr` stable at 0x0 for all 5 request cycles; `ins_valid` asserts exactly 1 cycle after `rvalid`.
- HOLD with `advance`=0 for 10 cycles: `ins`, `pc`, and `ins_valid` stay constant. Then `advance`=1, `pcsel`=1, `alu_target`=0x0000_0101: next `pc`=0x100, `imem_req`=1 next cycle.
- `advance`=1, `pcsel`=1, `alu_target`=0x0000_0206: next cycle `fetch_fault`=1, `pc`=0x206, `imem_req`=0, `ins_valid`=0. Both stay so through 20 cycles of `imem_ready`/`rvalid` toggling, until `rst_n`=0.
- `pc`=0xFFFF_FFFC, `advance`=1, `pcsel`=0: `pc_plus4` before advance is 0x0; next `pc`=0x0.
- Assert `rst_n`=0 in WAIT, deassert, then drive a stale `imem_rvalid`=1 with 0xDEADBEEF in the REQ cycle. Required: `ins` stays `NOP_INSN`, `ins_valid`=0, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding request/response
// handshake to instruction memory and presents one registered instruction to decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        pcsel,
  input  logic [31:0] alu_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic        ins_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] ins_nxt;
  logic [31:0] target_pc;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= REQ;
      pc    <= RESET_PC;
      ins   <= NOP_INSN;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ins   <= ins_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ins_nxt     = ins;
    imem_req    = 1'b0;
    ins_valid   = 1'b0;
    fetch_fault = 1'b0;
    // Bit 0 of a jump target is always cleared; bit 1 set means a misaligned fetch.
    target_pc   = pcsel ? (alu_target & ~32'h1) : pc_plus4;

    case (state)
      REQ: begin
        imem_req = 1'b1;
        if (imem_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          ins_nxt   = imem_rdata;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        ins_valid = 1'b1;
        if (advance) begin
          pc_nxt    = target_pc;
          state_nxt = target_pc[1] ? FAULT : REQ;
        end
      end
      FAULT: begin
        fetch_fault = 1'b1;
      end
      default: state_nxt = REQ;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scripted scenarios plus randomized fetch/jump traffic
// compared against a transaction-level model of the expected PC and instruction.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        advance = 1'b0;
  logic        pcsel = 1'b0;
  logic [31:0] alu_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ins;
  logic        ins_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_fault;

  int checks = 0;
  int failures = 0;

  // Model state: address of the instruction being fetched/held and its last loaded word.
  logic [31:0] exp_pc;
  logic [31:0] exp_ins;

  instr_fetch #(.RESET_PC(RESET_PC), .NOP_INSN(NOP_INSN)) dut (
    .clk(clk), .rst_n(rst_n), .advance(advance), .pcsel(pcsel), .alu_target(alu_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .ins(ins), .ins_valid(ins_valid),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0; advance = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    #1;
    checks++; if (pc !== RESET_PC) begin failures++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
    checks++; if (ins !== NOP_INSN) begin failures++; $display("FAIL reset_ins: got %h want %h", ins, NOP_INSN); end
    checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL reset_ins_valid: got %b want 0", ins_valid); end
    checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL reset_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
    checks++; if (pc_plus4 !== RESET_PC + 32'd4) begin failures++; $display("FAIL reset_pc_plus4: got %h want %h", pc_plus4, RESET_PC + 32'd4); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = RESET_PC;
    exp_ins = NOP_INSN;
  endtask

  // Starts at a negedge with the DUT requesting; ends at the negedge where ins is valid.
  task automatic fetch(input logic [31:0] data, input int unsigned rdy_dly, input int unsigned rv_dly);
    for (int unsigned i = 0; i <= rdy_dly; i++) begin
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL fetch_req: got %b want 1 (pc %h)", imem_req, exp_pc); end
      checks++; if (imem_addr !== exp_pc) begin failures++; $display("FAIL fetch_addr: got %h want %h", imem_addr, exp_pc); end
      checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL fetch_req_valid: got %b want 0", ins_valid); end
      imem_ready  = (i == rdy_dly);
      imem_rvalid = 1'($urandom);
      imem_rdata  = $urandom;
      advance     = 1'($urandom);
      pcsel       = 1'($urandom);
      alu_target  = $urandom;
      @(negedge clk);
    end
    for (int unsigned i = 0; i <= rv_dly; i++) begin
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL wait_req: got %b want 0", imem_req); end
      checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL wait_valid: got %b want 0", ins_valid); end
      imem_ready  = 1'($urandom);
      imem_rvalid = (i == rv_dly);
      imem_rdata  = (i == rv_dly) ? data : $urandom;
      @(negedge clk);
    end
    imem_rvalid = 1'b0;
    imem_ready  = 1'b0;
    advance     = 1'b0;
    exp_ins     = data;
    checks++; if (ins_valid !== 1'b1) begin failures++; $display("FAIL hold_valid: got %b want 1", ins_valid); end
    checks++; if (ins !== data) begin failures++; $display("FAIL hold_ins: got %h want %h", ins, data); end
    checks++; if (pc !== exp_pc) begin failures++; $display("FAIL hold_pc: got %h want %h", pc, exp_pc); end
    checks++; if (pc_plus4 !== exp_pc + 32'd4) begin failures++; $display("FAIL hold_pc_plus4: got %h want %h", pc_plus4, exp_pc + 32'd4); end
  endtask

  // Issues one honoured advance from HOLD and checks the following cycle.
  task automatic step(input logic sel, input logic [31:0] tgt);
    logic [31:0] nxt;
    nxt = sel ? (tgt & 32'hFFFF_FFFE) : exp_pc + 32'd4;
    advance = 1'b1; pcsel = sel; alu_target = tgt;
    @(negedge clk);
    advance = 1'b0; pcsel = 1'($urandom); alu_target = $urandom;
    exp_pc = nxt;
    checks++; if (pc !== nxt) begin failures++; $display("FAIL step_pc: got %h want %h", pc, nxt); end
    checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL step_valid: got %b want 0", ins_valid); end
    checks++; if (imem_req !== !nxt[1]) begin failures++; $display("FAIL step_req: got %b want %b", imem_req, !nxt[1]); end
    checks++; if (fetch_fault !== nxt[1]) begin failures++; $display("FAIL step_fault: got %b want %b", fetch_fault, nxt[1]); end
    checks++; if (ins !== exp_ins) begin failures++; $display("FAIL step_ins_kept: got %h want %h", ins, exp_ins); end
  endtask

  task automatic test_zero_wait;
    test_reset();
    imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    advance = 1'b1; pcsel = 1'b0;
    for (int unsigned k = 0; k < 9; k++) begin
      checks++; if (imem_req !== (k % 3 == 0)) begin failures++; $display("FAIL zw_req[%0d]: got %b want %b", k, imem_req, (k % 3 == 0)); end
      checks++; if (ins_valid !== (k % 3 == 2)) begin failures++; $display("FAIL zw_valid[%0d]: got %b want %b", k, ins_valid, (k % 3 == 2)); end
      if (k % 3 == 0) begin
        checks++; if (imem_addr !== 32'(4 * (k / 3))) begin failures++; $display("FAIL zw_addr[%0d]: got %h want %h", k, imem_addr, 32'(4 * (k / 3))); end
      end
      if (k % 3 == 2) begin
        checks++; if (ins !== 32'h0050_0093) begin failures++; $display("FAIL zw_ins[%0d]: got %h want 00500093", k, ins); end
      end
      @(negedge clk);
    end
    advance = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    exp_pc = 32'd12;
    exp_ins = 32'h0050_0093;
    fetch($urandom, 0, 0);
  endtask

  task automatic test_stall;
    test_reset();
    fetch(32'h0050_0093, 4, 1);
  endtask

  task automatic test_hold;
    for (int unsigned i = 0; i < 10; i++) begin
      advance = 1'b0; pcsel = 1'($urandom); alu_target = $urandom;
      imem_ready = 1'($urandom); imem_rvalid = 1'($urandom); imem_rdata = $urandom;
      @(negedge clk);
      checks++; if (ins !== exp_ins) begin failures++; $display("FAIL idle_ins[%0d]: got %h want %h", i, ins, exp_ins); end
      checks++; if (pc !== exp_pc) begin failures++; $display("FAIL idle_pc[%0d]: got %h want %h", i, pc, exp_pc); end
      checks++; if (ins_valid !== 1'b1) begin failures++; $display("FAIL idle_valid[%0d]: got %b want 1", i, ins_valid); end
    end
    imem_ready = 1'b0; imem_rvalid = 1'b0;
    step(1'b1, 32'h0000_0101);
    checks++; if (pc !== 32'h0000_0100) begin failures++; $display("FAIL jump_pc: got %h want 00000100", pc); end
    fetch($urandom, $urandom_range(0, 2), $urandom_range(0, 2));
  endtask

  task automatic test_fault;
    step(1'b1, 32'h0000_0206);
    for (int unsigned i = 0; i < 20; i++) begin
      imem_ready = 1'($urandom); imem_rvalid = 1'($urandom); imem_rdata = $urandom;
      advance = 1'($urandom); pcsel = 1'($urandom); alu_target = $urandom;
      @(negedge clk);
      checks++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL fault_sticky[%0d]: got %b want 1", i, fetch_fault); end
      checks++; if (pc !== 32'h0000_0206) begin failures++; $display("FAIL fault_pc[%0d]: got %h want 00000206", i, pc); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL fault_req[%0d]: got %b want 0", i, imem_req); end
      checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL fault_valid[%0d]: got %b want 0", i, ins_valid); end
    end
    test_reset();
  endtask

  task automatic test_wrap;
    fetch($urandom, 0, 0);
    step(1'b1, 32'hFFFF_FFFD);
    fetch($urandom, 1, 0);
    checks++; if (pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_pc_plus4: got %h want 00000000", pc_plus4); end
    step(1'b0, $urandom);
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc: got %h want 00000000", pc); end
    fetch($urandom, 0, 1);
  endtask

  task automatic test_stale_after_reset;
    test_reset();
    fetch(32'h1234_5678, 0, 0);
    step(1'b0, $urandom);
    imem_ready = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ins !== NOP_INSN) begin failures++; $display("FAIL async_ins: got %h want %h", ins, NOP_INSN); end
    checks++; if (pc !== RESET_PC) begin failures++; $display("FAIL async_pc: got %h want %h", pc, RESET_PC); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL async_req: got %b want 1", imem_req); end
    @(negedge clk);
    rst_n = 1'b1;
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    checks++; if (ins !== NOP_INSN) begin failures++; $display("FAIL stale_ins: got %h want %h", ins, NOP_INSN); end
    checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL stale_valid: got %b want 0", ins_valid); end
    checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL stale_addr: got %h want %h", imem_addr, RESET_PC); end
    exp_pc = RESET_PC;
    exp_ins = NOP_INSN;
    fetch($urandom, 0, 0);
  endtask

  task automatic test_random;
    logic [31:0] tgt;
    for (int unsigned n = 0; n < 40; n++) begin
      step(1'($urandom), $urandom & 32'hFFFF_FFFD);
      fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    tgt = $urandom | 32'h2;
    step(1'b1, tgt);
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_hold();
    test_fault();
    test_wrap();
    test_stale_after_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
